// File: rtl/fifo_dest_demux_pkg.sv
// Shared types and defaults for the FIFO destination demux: FSM state encoding,
// default word/destination widths and a helper that extracts the destination field.
package fifo_dest_demux_pkg;

  localparam int DEFAULT_DATA_WIDTH = 10;
  localparam int DEFAULT_DEST_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2,
    ERROR  = 2'd3
  } demux_state_t;

  // Destination lives in the top bits of the word at the default widths.
  function automatic logic [DEFAULT_DEST_WIDTH-1:0] dest_field(
    input logic [DEFAULT_DATA_WIDTH-1:0] word
  );
    return word[DEFAULT_DATA_WIDTH-1 -: DEFAULT_DEST_WIDTH];
  endfunction

endpackage

// File: rtl/fifo_dest_demux_dest_word_counter.sv
// Single wrapping word counter; one instance per destination tracks delivered words.
module dest_word_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;

  // Natural binary overflow provides the wrap back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fifo_dest_demux.sv
// Drains the upstream FIFO and routes each word to one of NUM_DEST downstream FIFOs.
// Define DEMUX_COUNT_EN to build the per-destination delivered-word counters.
module fifo_dest_demux
  import fifo_dest_demux_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEST_WIDTH = DEFAULT_DEST_WIDTH,
  parameter  int CNT_WIDTH  = 8,
  localparam int NUM_DEST   = 2**DEST_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  input  logic [NUM_DEST-1:0]   dest_almost_full,
  input  logic [NUM_DEST-1:0]   dest_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_DEST-1:0]   push_out,
  output logic                  idle,
  output logic                  error,
  input  logic [DEST_WIDTH-1:0] cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_out
);

  demux_state_t          state_reg;
  demux_state_t          state_next;
  logic                  in_flight_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic [NUM_DEST-1:0]   push_out_reg;
  logic                  error_reg;
  logic [DEST_WIDTH-1:0] word_dest;
  logic                  capture;
  logic                  overflow;
  logic                  deliver;

  assign word_dest = fifo_data[DATA_WIDTH-1 -: DEST_WIDTH];

  // A word that arrives after ERROR was entered is discarded rather than routed.
  assign capture  = in_flight_reg && (state_reg != ERROR);
  assign overflow = capture && dest_full[word_dest];
  assign deliver  = capture && !dest_full[word_dest];

  always_comb begin
    fifo_pop = 1'b0;
    if ((state_reg == IDLE || state_reg == ACTIVE) && !fifo_empty &&
        (dest_almost_full == '0)) begin
      fifo_pop = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (|dest_almost_full) state_next = HOLD;
        else if (fifo_empty)   state_next = IDLE;
      end
      HOLD: begin
        if (dest_almost_full == '0) state_next = fifo_empty ? IDLE : ACTIVE;
      end
      ERROR: state_next = ERROR;
      default: state_next = IDLE;
    endcase
    if (overflow) state_next = ERROR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      in_flight_reg <= 1'b0;
      data_out_reg  <= '0;
      push_out_reg  <= '0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_flight_reg <= fifo_pop;
      push_out_reg  <= '0;
      if (overflow) begin
        error_reg <= 1'b1;
      end
      if (deliver) begin
        push_out_reg <= NUM_DEST'(1) << word_dest;
        data_out_reg <= fifo_data;
      end
    end
  end

  assign data_out = data_out_reg;
  assign push_out = push_out_reg;
  assign error    = error_reg;
  assign idle     = (state_reg == IDLE) && !in_flight_reg && fifo_empty;

`ifdef DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] count_arr [NUM_DEST];

  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_cnt
    dest_word_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (push_out_reg[gi]),
      .count (count_arr[gi])
    );
  end

  assign cnt_out = count_arr[cnt_sel];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_fifo_dest_demux.sv
// Scoreboard bench for fifo_dest_demux: models the upstream FIFO with a registered read
// and compares every routed word against the queue of words expected to emerge.
module tb_fifo_dest_demux;
  import fifo_dest_demux_pkg::*;

  localparam int DW = 10;
  localparam int NW = 2;
  localparam int ND = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic [ND-1:0] dest_almost_full = '0;
  logic [ND-1:0] dest_full = '0;
  logic [NW-1:0] cnt_sel = '0;
  logic          fifo_pop;
  logic [DW-1:0] data_out;
  logic [ND-1:0] push_out;
  logic          idle;
  logic          error;
  logic [CW-1:0] cnt_out;

  always #5 clk = ~clk;

  fifo_dest_demux #(
    .DATA_WIDTH(DW),
    .DEST_WIDTH(NW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_data        (fifo_data),
    .fifo_pop         (fifo_pop),
    .dest_almost_full (dest_almost_full),
    .dest_full        (dest_full),
    .data_out         (data_out),
    .push_out         (push_out),
    .idle             (idle),
    .error            (error),
    .cnt_sel          (cnt_sel),
    .cnt_out          (cnt_out)
  );

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            checks_count = 0;
  int            errors_count = 0;
  int            push_cnt = 0;
  logic [DW-1:0] last_data = '0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_count++;
    if (got !== want) begin
      errors_count++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic load(input logic [DW-1:0] w, input bit expect_out);
    src_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic monitor();
    logic [DW-1:0] w;
    if (push_out != '0) begin
      if (exp_q.size() == 0) begin
        check_value("unexp_push", 32'(push_out), 32'd0);
      end else begin
        w = exp_q.pop_front();
        check_value("push_onehot", 32'(push_out), 32'd1 << dest_field(w));
        check_value("push_data", 32'(data_out), 32'(w));
        push_cnt++;
        last_data = data_out;
        $display("push dest_mask=%b data=0x%03h", push_out, data_out);
      end
    end
  endtask

  // One clock: sample pop before the edge, apply the registered FIFO read after it,
  // then observe DUT outputs on the falling edge.
  task automatic step();
    logic pop_now;
    #1;
    pop_now = fifo_pop;
    @(posedge clk);
    #1;
    if (pop_now && !reset && src_q.size() > 0) fifo_data = src_q.pop_front();
    fifo_empty = (src_q.size() == 0);
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(src_q.size() == 0 && exp_q.size() == 0 && idle) && n < budget) begin
      step();
      n++;
    end
    check_value("drain_done", 32'(src_q.size() == 0 && exp_q.size() == 0 && idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int want_cnt;

    // Reset state while reset is still held.
    repeat (2) @(negedge clk);
    check_value("rst_pop", 32'(fifo_pop), 32'd0);
    check_value("rst_data", 32'(data_out), 32'd0);
    check_value("rst_push", 32'(push_out), 32'd0);
    check_value("rst_idle", 32'(idle), 32'd1);
    check_value("rst_error", 32'(error), 32'd0);
    check_value("rst_cnt", 32'(cnt_out), 32'd0);
    reset = 1'b0;

    // Empty FIFO: nothing happens.
    for (int i = 0; i < 10; i++) begin
      step();
      check_value("empty_pop", 32'(fifo_pop), 32'd0);
      check_value("empty_push", 32'(push_out), 32'd0);
      check_value("empty_idle", 32'(idle), 32'd1);
      check_value("empty_error", 32'(error), 32'd0);
    end

    // One word per destination, back to back, two-cycle latency.
    load(10'h0A5, 1'b1);
    load(10'h15A, 1'b1);
    load(10'h2FF, 1'b1);
    load(10'h300, 1'b1);
    base = push_cnt;
    step();
    check_value("t2_latency", 32'(push_cnt), 32'(base));
    for (int i = 1; i <= 4; i++) begin
      step();
      check_value("t2_consec", 32'(push_cnt), 32'(base + i));
    end
    drain(20);

    // Almost-full mid-stream: in-flight word still lands, then hold.
    load(10'h011, 1'b1);
    load(10'h122, 1'b1);
    load(10'h233, 1'b1);
    load(10'h344, 1'b1);
    load(10'h055, 1'b1);
    load(10'h166, 1'b1);
    step();
    step();
    dest_almost_full = 4'b0100;
    #1;
    check_value("t3_pop_drop", 32'(fifo_pop), 32'd0);
    base = push_cnt;
    step();
    check_value("t3_inflight", 32'(push_cnt), 32'(base + 1));
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("t3_hold_pop", 32'(fifo_pop), 32'd0);
      check_value("t3_hold_push", 32'(push_cnt), 32'(base + 1));
    end
    dest_almost_full = 4'b0000;
    #1;
    check_value("t3_release_same", 32'(fifo_pop), 32'd0);
    step();
    check_value("t3_resume", 32'(fifo_pop), 32'd1);
    drain(30);

    // Overflow into a full destination: drop, sticky error, no more pops.
    dest_full = 4'b0010;
    load(10'h155, 1'b0);
    load(10'h0AA, 1'b0);
    load(10'h2AA, 1'b0);
    base = push_cnt;
    step();
    check_value("t4_pre_err", 32'(error), 32'd0);
    step();
    check_value("t4_drop_push", 32'(push_out), 32'd0);
    check_value("t4_err", 32'(error), 32'd1);
    check_value("t4_data_hold", 32'(data_out), 32'(last_data));
    check_value("t4_no_pop", 32'(fifo_pop), 32'd0);
    dest_full = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("t4_stuck_pop", 32'(fifo_pop), 32'd0);
      check_value("t4_stuck_err", 32'(error), 32'd1);
      check_value("t4_stuck_idle", 32'(idle), 32'd0);
    end
    check_value("t4_no_delivery", 32'(push_cnt), 32'(base));
    src_q.delete();
    fifo_empty = 1'b1;
    reset = 1'b1;
    #1;
    check_value("t4_rst_err", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset while a word is in flight: async clear, word never appears.
    load(10'h2C3, 1'b1);
    load(10'h1D4, 1'b1);
    step();
    step();
    check_value("t5_pre_push", 32'(push_out), 32'b0100);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_value("t5_async_push", 32'(push_out), 32'd0);
    check_value("t5_async_data", 32'(data_out), 32'd0);
    base = push_cnt;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_value("t5_lost", 32'(push_cnt), 32'(base));
    check_value("t5_idle", 32'(idle), 32'd1);

    // 300 words to destination 2, then read back the counters.
    base = push_cnt;
    for (int i = 0; i < 300; i++) load({2'b10, 8'(i)}, 1'b1);
    drain(400);
    step();
    check_value("t6_pushes", 32'(push_cnt), 32'(base + 300));
    for (int s = 0; s < ND; s++) begin
      cnt_sel = NW'(s);
      #1;
`ifdef DEMUX_COUNT_EN
      want_cnt = (s == 2) ? 44 : 0;
`else
      want_cnt = 0;
`endif
      check_value("t6_cnt", 32'(cnt_out), 32'(want_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
    $finish;
  end

endmodule

// File: doc/fifo_dest_demux.md
Name: fifo_dest_demux

Overview:
- Downstream consumer of the 10-bit input FIFO.
- Pops words while the FIFO is non-empty and every destination has room.
- Decodes the destination field in the word's top bits and pushes the full word to exactly one of 4 downstream FIFOs (one-hot push, shared data bus).
- Detects overflow into a full destination, drops the word and latches an error.

Parameters:
- DATA_WIDTH, 10, word width; payload is [DATA_WIDTH-DEST_WIDTH-1:0], destination is [DATA_WIDTH-1:DATA_WIDTH-DEST_WIDTH].
- DEST_WIDTH, 2, destination field width; NUM_DEST = 2**DEST_WIDTH (4), derived, not overridable.
- CNT_WIDTH, 8, width of per-destination word counters (optional feature only).

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- fifo_empty, input, 1, upstream FIFO empty flag.
- fifo_data, input, DATA_WIDTH, upstream FIFO read data; valid the cycle after fifo_pop (registered read).
- fifo_pop, output, 1, pop request to upstream FIFO.
- dest_almost_full, input, NUM_DEST, per-destination almost-full; assert threshold leaves ≥2 free slots.
- dest_full, input, NUM_DEST, per-destination full.
- data_out, output, DATA_WIDTH, registered routed word (shared by all destinations).
- push_out, output, NUM_DEST, one-hot push, qualifies data_out.
- idle, output, 1, high when no word is in flight and the FIFO is empty.
- error, output, 1, sticky overflow flag.
- cnt_sel, input, DEST_WIDTH, selects counter for cnt_out.
- cnt_out, output, CNT_WIDTH, selected destination word count.

Behaviour:
- Reset values: fifo_pop=0, data_out=0, push_out=0, idle=1, error=0, cnt_out=0, all counters 0, FSM=IDLE, in-flight flag=0.
- FSM states: IDLE, ACTIVE, HOLD, ERROR.
  - IDLE→ACTIVE when !fifo_empty.
  - ACTIVE→HOLD when |dest_almost_full.
  - HOLD→ACTIVE when dest_almost_full==0 and !fifo_empty.
  - HOLD→IDLE when dest_almost_full==0 and fifo_empty.
  - ACTIVE→IDLE when fifo_empty.
  - Any state→ERROR on an overflow event.
  - ERROR exits only on reset.
- fifo_pop is combinational: state∈{IDLE,ACTIVE} && !fifo_empty && dest_almost_full==0. Never pops in HOLD or ERROR.
- In-flight flag is registered fifo_pop. While it is 1, fifo_data is consumed at that clock edge.
- Latency: pop in cycle N → fifo_data valid in cycle N+1 → data_out/push_out valid in cycle N+2. Throughput is 1 word/cycle sustained.
- Routing: d = fifo_data[DATA_WIDTH-1 -: DEST_WIDTH]; push_out <= (1<<d), data_out <= fifo_data. push_out is 0 in cycles with no consumed word.
- Overflow event: consumed word with dest_full[d]=1 at the capture edge.
  - Word is dropped: push_out=0, data_out holds its previous value.
  - error<=1 and FSM→ERROR.
  - A word already in flight when ERROR is entered is discarded silently.
- Simultaneous events: a pop and a capture in the same cycle are normal pipelining. almost_full rising in the same cycle as a pop does not cancel the already-issued in-flight word; it is still delivered.
- idle = (state==IDLE) && !in_flight && fifo_empty.
- Reset mid-transfer: the in-flight word is lost and push_out clears asynchronously. The upstream FIFO's own reset handles its side.

Optional Feature:
- Macro DEMUX_COUNT_EN.
- Defined: one CNT_WIDTH counter per destination increments on each push_out bit and wraps at 2**CNT_WIDTH-1 → 0. Reset clears it. cnt_out = counter[cnt_sel], combinational.
- Undefined: no counters; cnt_out tied to 0 and cnt_sel ignored. Ports remain present so the bench is unchanged.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, HOLD=2'd2, ERROR=2'd3), DATA_WIDTH/DEST_WIDTH defaults, dest-field slice helper.
- One natural sub-module, dest_word_counter: a single CNT_WIDTH wrapping counter instantiated NUM_DEST times under DEMUX_COUNT_EN.

Test Plan:
- Reset, then FIFO empty 10 cycles → fifo_pop=0, push_out=0, idle=1, error=0.
- FIFO holds 0x0A5, 0x15A, 0x2FF, 0x300, no backpressure → push_out 0001, 0010, 0100, 1000 on 4 consecutive cycles starting 2 cycles after the first pop, with matching data_out.
- dest_almost_full=4'b0100 raised mid-stream → fifo_pop drops the same cycle and HOLD is entered. The single in-flight word is still delivered; popping resumes the cycle after release.
- dest_full[1]=1 while 0x155 is captured → push_out=0, error=1 next edge, FSM stays ERROR and fifo_pop stays 0 until reset.
- Reset asserted while a word is in flight → outputs clear without a clock edge; after release the word never appears.
- With DEMUX_COUNT_EN: 300 words to dest 2 → cnt_sel=2 reads 44 (300 mod 256), other counters 0. Without the macro, cnt_out=0.
